// File: rtl/mult_unit_pkg.sv
// Shared definitions for the iterative shift-add multiplier: state encoding,
// iteration count, datapath widths and the operand magnitude helper.
package mult_unit_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      FIX  = 2'd2
   } state_t;

   localparam int ITER_COUNT = 32;
   localparam int DATA_W     = 64;
   localparam int OP_W       = DATA_W / 2;
   localparam int CNT_W      = $clog2(ITER_COUNT);

   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(ITER_COUNT - 1);

   // The most negative operand maps onto itself, which is the correct
   // unsigned magnitude 2^31.
   function automatic logic [OP_W-1:0] magnitude(input logic [OP_W-1:0] value,
                                                 input logic take_abs);
      return (take_abs && value[OP_W-1]) ? (~value + OP_W'(1)) : value;
   endfunction

endpackage

// File: rtl/adder64.sv
// Plain 64-bit adder; overflow reports the carry out of the top bit.
module adder64 (
   input  logic [63:0] a,
   input  logic [63:0] b,
   output logic [63:0] sum,
   output logic        overflow
);

   logic [64:0] full_sum;

   assign full_sum = {1'b0, a} + {1'b0, b};
   assign sum      = full_sum[63:0];
   assign overflow = full_sum[64];

endmodule

// File: rtl/mult_unit.sv
// 32x32 -> 64 multiplier (MULT/MULTU): one multiplier bit per cycle on
// operand magnitudes, followed by a single sign-fix cycle.
module mult_unit
   import mult_unit_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            is_signed,
   input  logic [OP_W-1:0] op_a,
   input  logic [OP_W-1:0] op_b,
   output logic            busy,
   output logic            done,
   output logic [OP_W-1:0] hi,
   output logic [OP_W-1:0] lo
);

   state_t              state;
   state_t              state_next;
   logic [OP_W-1:0]     mcand;
   logic [OP_W-1:0]     mplier;
   logic                neg;
   logic [DATA_W-1:0]   acc;
   logic [CNT_W-1:0]    count;
   logic [DATA_W-1:0]   add_a;
   logic [DATA_W-1:0]   add_b;
   logic [DATA_W-1:0]   add_sum;
   logic [DATA_W-1:0]   product;
   logic                ovf_unused;

   // The single adder accumulates shifted partial products during ITER and
   // forms the two's complement of the accumulator during FIX.
   always_comb begin
      state_next = state;
      add_a      = acc;
      add_b      = '0;
      case (state)
         IDLE: begin
            if (start) state_next = ITER;
         end
         ITER: begin
            if (mplier[count]) add_b = {{OP_W{1'b0}}, mcand} << count;
            if (count == LAST_COUNT) state_next = FIX;
         end
         FIX: begin
            add_a      = ~acc;
            add_b      = DATA_W'(1);
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   adder64 u_adder (
      .a        (add_a),
      .b        (add_b),
      .sum      (add_sum),
      .overflow (ovf_unused)
   );

   assign product = neg ? add_sum : acc;
   assign busy    = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Operands are latched only from IDLE, so start pulses while busy are
   // ignored; hi/lo move only on the FIX edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         mcand  <= '0;
         mplier <= '0;
         neg    <= 1'b0;
         acc    <= '0;
         count  <= '0;
         hi     <= '0;
         lo     <= '0;
         done   <= 1'b0;
      end else begin
         done <= (state == FIX);
         case (state)
            IDLE: begin
               if (start) begin
                  mcand  <= magnitude(op_a, is_signed);
                  mplier <= magnitude(op_b, is_signed);
                  neg    <= is_signed & (op_a[OP_W-1] ^ op_b[OP_W-1]);
                  acc    <= '0;
                  count  <= '0;
               end
            end
            ITER: begin
               acc   <= add_sum;
               count <= count + CNT_W'(1);
            end
            FIX: begin
               hi <= product[DATA_W-1:OP_W];
               lo <= product[OP_W-1:0];
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_unit.sv
// Scoreboard bench for mult_unit: accepted starts push a reference product and
// due cycle, which the negedge monitor pops against done/hi/lo.
module tb_mult_unit;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int unsigned due;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        is_signed = 1'b0;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   exp_t        sb[$];
   int unsigned edgeNo = 0;
   int          passCount = 0;
   int          checkCount = 0;
   logic [63:0] modelHiLo = '0;
   bit          pendingReset = 1'b0;

   always #5 clk = ~clk;

   mult_unit dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .is_signed (is_signed),
      .op_a      (op_a),
      .op_b      (op_b),
      .busy      (busy),
      .done      (done),
      .hi        (hi),
      .lo        (lo)
   );

   always @(posedge clk) edgeNo <= edgeNo + 1;

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
   endtask

   function automatic logic [63:0] refProduct(input logic [31:0] a, input logic [31:0] b,
                                              input logic sgn);
      logic signed [63:0] sa;
      logic signed [63:0] sbv;
      if (sgn) begin
         sa  = {{32{a[31]}}, a};
         sbv = {{32{b[31]}}, b};
         return 64'(sa * sbv);
      end
      return {32'b0, a} * {32'b0, b};
   endfunction

   // Monitor: outputs are sampled at negedge, inputs seen here are the ones
   // the next rising edge will sample.
   always @(negedge clk) begin
      exp_t        e;
      logic        expDone;
      logic [63:0] prod;
      if (pendingReset) begin
         sb.delete();
         modelHiLo = '0;
         checkOutput("reset_busy", {63'b0, busy}, 64'd0);
      end
      expDone = (sb.size() > 0) && (sb[0].due == edgeNo);
      if (done || expDone) begin
         checkOutput("done_pulse", {63'b0, done}, {63'b0, expDone});
         if (expDone) begin
            e = sb.pop_front();
            checkOutput("hi", {32'b0, hi}, {32'b0, e.hi});
            checkOutput("lo", {32'b0, lo}, {32'b0, e.lo});
            checkOutput("busy_at_done", {63'b0, busy}, 64'd0);
            modelHiLo = {e.hi, e.lo};
         end
      end else begin
         checkOutput("hold", {hi, lo}, modelHiLo);
      end
      pendingReset = rst;
      if (!rst && start && !busy) begin
         prod  = refProduct(op_a, op_b, is_signed);
         e.hi  = prod[63:32];
         e.lo  = prod[31:0];
         e.due = edgeNo + 1 + 33;
         sb.push_back(e);
      end
   end

   task automatic waitCycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sgn);
      op_a      = a;
      op_b      = b;
      is_signed = sgn;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start     = 1'b0;
      op_a      = $urandom;
      op_b      = $urandom;
      is_signed = 1'($urandom_range(0, 1));
   endtask

   task automatic waitIdle();
      int budget = 0;
      while ((sb.size() != 0 || busy) && budget < 100) begin
         @(posedge clk);
         #1;
         budget++;
      end
      if (budget >= 100) checkOutput("idle_timeout", 64'd1, 64'd0);
   endtask

   task automatic waitDone();
      int budget = 0;
      while (!done && budget < 100) begin
         @(posedge clk);
         #1;
         budget++;
      end
      if (budget >= 100) checkOutput("done_timeout", 64'd1, 64'd0);
   endtask

   initial begin
      waitCycles(3);
      rst = 1'b0;
      waitCycles(2);

      applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      waitIdle();
      applyStimulus(32'hFFFF_FFFF, 32'h0000_0002, 1'b1);
      waitIdle();
      applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b1);
      waitIdle();
      applyStimulus(32'h8000_0000, 32'h0000_0003, 1'b1);
      waitIdle();
      applyStimulus(32'h0001_2345, 32'h0000_0000, 1'b1);
      waitIdle();

      for (int i = 0; i < 6; i++) begin
         applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)));
         waitIdle();
      end

      // Start pulses with fresh operands at cycles 5 and 20 must be ignored.
      applyStimulus(32'h0000_1234, 32'h0000_5678, 1'b0);
      waitCycles(4);
      applyStimulus(32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1);
      waitCycles(14);
      applyStimulus(32'h7FFF_FFFF, 32'h8000_0001, 1'b1);
      waitIdle();

      // Reset around ITER cycle 10 kills the operation silently.
      applyStimulus(32'h1357_9BDF, 32'h2468_ACE0, 1'b0);
      waitCycles(9);
      rst = 1'b1;
      waitCycles(1);
      rst = 1'b0;
      waitCycles(40);

      rst = 1'b1;
      applyStimulus(32'h0000_0005, 32'h0000_0005, 1'b0);
      rst = 1'b0;
      waitCycles(40);

      // Back-to-back: the second start lands in the done cycle of the first.
      applyStimulus(32'hFFFF_FFF0, 32'h0000_0010, 1'b1);
      waitDone();
      applyStimulus(32'h0000_0007, 32'h0000_0006, 1'b0);
      waitIdle();
      waitCycles(3);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/mult_unit.md
MULT_UNIT -- requirements
Module: mult_unit

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  request a new multiply; sampled only when busy=0.
REQ-005 is_signed  input  1  1 = MULT (two's complement), 0 = MULTU; captured with start.
REQ-006 op_a  input  32  multiplicand (rs); captured with start.
REQ-007 op_b  input  32  multiplier (rt); captured with start.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse: hi/lo were just updated.
REQ-010 hi  output  32  upper 32 bits of the last 64-bit product.
REQ-011 lo  output  32  lower 32 bits of the last 64-bit product.

Function
REQ-012 SHALL implement three states: IDLE, ITER, FIX.
REQ-013 IDLE: start=1 at a clock edge SHALL capture the operands and move to ITER.
- Operands are stored as |op_a| and |op_b| when is_signed=1, raw otherwise.
- Captured sign is neg = is_signed & (op_a[31] ^ op_b[31]).
- Clears the 64-bit accumulator and the 5-bit counter.
- busy=1 from the next cycle.
REQ-014 ITER SHALL run exactly 32 cycles, with one multiplier bit per cycle, LSB first.
- If the bit is 1, the accumulator becomes accumulator + (zero-extended multiplicand << count), computed with adder64.
- The counter increments; after count=31 the state moves to FIX.
REQ-015 FIX SHALL last 1 cycle.
- Product = neg ? (~accumulator + 1, computed with adder64) : accumulator.
- At the FIX edge: hi<=product[63:32], lo<=product[31:0], state goes to IDLE.
- done=1 and busy=0 in the following cycle.
REQ-016 Latency: hi, lo and done SHALL become valid exactly 33 cycles after the edge that accepted start; the unit is not pipelined.
REQ-017 start while busy=1 SHALL be ignored; operands and is_signed SHALL NOT be re-captured.
REQ-018 start during the done cycle (busy=0) SHALL be accepted.
- done still pulses for exactly 1 cycle.
- hi/lo hold the previous result until the next FIX.
REQ-019 hi and lo SHALL hold their value between operations.
- They change only at the FIX edge or at reset.
REQ-020 The adder64 overflow output SHALL be ignored.
- The 32x32 magnitude product fits in 64 bits.
- Signed -2^31 operands are handled as magnitude 2^31 in 32-bit unsigned.
REQ-021 done SHALL NOT assert in any cycle other than the one immediately after FIX.

Reset
REQ-022 rst=1 at a clock edge SHALL force the following, regardless of state, including mid-ITER or FIX:
- state=IDLE, busy=0, done=0, hi=0, lo=0;
- accumulator and counter = 0.
REQ-023 An operation interrupted by reset SHALL produce no done pulse and no hi/lo update.
REQ-024 start asserted together with rst SHALL be ignored.

Structure
REQ-025 A shared package SHALL hold:
- the state encoding constants IDLE/ITER/FIX;
- the ITER count constant 32;
- the 64-bit data-width constant.
REQ-026 One instance of the existing adder64 SHALL be the only arithmetic sub-module.
- It is muxed between the accumulate addend (ITER) and the +1 negate addend (FIX).
- No behavioural '*' operator is permitted.

Verification
REQ-027 MULTU 0xFFFFFFFF x 0xFFFFFFFF:
- done at start-edge+33;
- hi=0xFFFFFFFE, lo=0x00000001.
REQ-028 MULT 0xFFFFFFFF (-1) x 0x00000002 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE.
REQ-029 MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-030 Start pulses while busy:
- start=1 with new operands at cycles 5 and 20 of an operation;
- only the first result appears;
- exactly one done pulse.
REQ-031 Reset mid-operation:
- rst at ITER cycle 10;
- busy=0, hi=lo=0 next cycle;
- no done within the following 40 cycles.
REQ-032 Back-to-back:
- start during the done cycle with 7 x 6 unsigned;
- the second done occurs 33 cycles later with hi=0, lo=0x2A;
- hi/lo hold the first result in between.
